jtpang_dial_ctrl: RTL and testbench
===================================

# jtpang_dial_ctrl

Parametrised dial/mouse input controller for the Mitchell-board main CPU I/O map, generalising the two-player "Block" dial handling to CH channels. Accumulates signed mouse deltas into per-channel position counters with clamping and sensitivity scaling. On a CPU select write it takes a coherent snapshot of all channels. It returns either the dial position or button/direction status through a registered read port feeding the main CPU input mux.

## Interface
Parameters:
- CH, 2: number of dial channels (players), 1..4
- DW, 8: position counter width (≥6); positions wrap modulo 2^DW
- SENS, 0: sensitivity shift; accumulator is DW+SENS bits, position = acc[DW+SENS-1:SENS]
- MAXD, 31: per-sample delta clamp magnitude, 1..127

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- mouse_dx  in  8*CH  signed two's-complement delta per channel, channel n in bits [8n+7:8n]
- mouse_st  in  CH  one-cycle strobe per channel, mouse_dx for that channel is valid this cycle
- btn  in  CH  fire button per channel, active low
- sel_we  in  1  CPU write strobe to the select register (one cycle per bus write)
- sel_din  in  8  CPU write data
- ch_sel  in  $clog2(CH) (min 1)  channel being read
- dial_mode  out  1  current read mode, 1 = dial position
- dout  out  8  registered read data
- pos_dbg  out  DW*CH  live positions, debug only

## Operation
- Delta path, per channel, on mouse_st[n]: d = clamp(mouse_dx[n], -MAXD, +MAXD), sign-extended to DW+SENS; acc[n] <= acc[n] + d, modulo 2^(DW+SENS), no saturation at wrap.
- Direction flag per channel: on mouse_st with d>0, dir_n <= 0; d<0, dir_n <= 1; d==0, unchanged.
- Select write (sel_we):
  - dial_mode <= ~sel_din[7].
  - If ~sel_din[7] is 1, snap[n] <= pos[n] for all n in the same cycle. Coherent across channels.
  - If sel_din[6] is 1, every acc[n] <= 0 after the snapshot value is taken.
- Read data, updated every cycle from ch_sel with c = ch_sel:
  - dial_mode=1: dout <= {snap[c][5:0], 2'b11}.
  - dial_mode=0: dout <= {btn[c], 3'b111, ~dir_n[c], 3'b111}. Bit 3 is the active-low direction, matching the existing non-dial format.
  - ch_sel ≥ CH: dout <= 8'hff.
- Simultaneous events:
  - mouse_st and snapshot on the same cycle: the snapshot captures the pre-update position, and the update is still applied to acc.
  - mouse_st and clear (sel_din[6]) on the same cycle: clear wins, acc = 0 and that delta is dropped.
  - dir_n still updates.
- Reset, also mid-operation: acc, snap = 0; dir_n = 1; dial_mode = 0; dout = 8'hff. Reset overrides all strobes in the same cycle.

## Timing
- Delta latency: mouse_st at cycle t gives the new acc/pos_dbg visible at t+1.
- Snapshot: sel_we at t gives snap valid at t+1 and dout reflecting it at t+2.
- Read latency: ch_sel/btn change at t appears on dout at t+1. No read strobe is needed, and reading has no side effects.
- Back-to-back mouse_st every cycle is supported on all channels independently.
- sel_we on consecutive cycles: each write is applied in order, and the last one determines dial_mode.
- All outputs registered; no combinational path from inputs to dout.

## Test plan
- Reset, then CH=2 DW=8 SENS=0, sel_din=8'h00 (dial mode), ch_sel=0 → dial_mode=1, dout=8'h03 by two cycles after sel_we.
- Ch0 strobes +5 three times, sel_din=8'h00, read ch0 → snap=15, dout={6'd15,2'b11}=8'h3f. Ch1 untouched gives dout=8'h03.
- Ch0 delta 8'h80 (-128) with MAXD=31 → acc=225 (0 - 31 wraps), pos_dbg[7:0]=8'he1, dir_n[0]=1.
- SENS=2: four strobes of +1 → pos stays 1 (acc=4). Then sel_din=8'h40 gives snap=1 and acc=0. Same-cycle mouse_st +3 → acc=0.
- sel_din=8'h80 (status mode), btn=2'b10, last ch1 delta +2, ch_sel=1 → dout=8'hff. With ch0 last delta -1 and ch_sel=0 → dout=8'h77.
- Assert rst one cycle mid-stream with mouse_st high → next cycle acc=0, snap=0, dial_mode=0, dout=8'hff.

Source files
------------

// File: rtl/jtpang_dial_ctrl_if.sv
// Dial controller bus: mouse delta/strobe inputs, buttons, CPU select write,
// channel read select, and the registered read/debug outputs.
// master = driver side (CPU + mouse front end); slave = jtpang_dial_ctrl.
interface jtpang_dial_ctrl_if #(
  parameter int CH = 2,
  parameter int DW = 8
);
  localparam int CSW = (CH > 1) ? $clog2(CH) : 1;

  logic [8*CH-1:0]  mouse_dx;   // signed delta per channel, ch n at [8n+7:8n]
  logic [CH-1:0]    mouse_st;   // one-cycle delta strobe per channel
  logic [CH-1:0]    btn;        // fire buttons, active low
  logic             sel_we;     // CPU write strobe to select register
  logic [7:0]       sel_din;    // CPU write data
  logic [CSW-1:0]   ch_sel;     // channel being read
  logic             dial_mode;  // 1 = reads return dial position
  logic [7:0]       dout;       // registered read data
  logic [DW*CH-1:0] pos_dbg;    // live positions, debug only

  modport master (
    output mouse_dx, mouse_st, btn, sel_we, sel_din, ch_sel,
    input  dial_mode, dout, pos_dbg
  );

  modport slave (
    input  mouse_dx, mouse_st, btn, sel_we, sel_din, ch_sel,
    output dial_mode, dout, pos_dbg
  );
endinterface

// File: rtl/jtpang_dial_ctrl.sv
// Dial/mouse controller for the Mitchell main CPU I/O map: accumulates clamped,
// sensitivity-scaled mouse deltas per channel, snapshots all channels coherently
// on a select write, and returns dial position or button/direction status.
// Ports: clk, rst (sync, active high), bus (jtpang_dial_ctrl_if.slave).
// Latency: delta -> pos_dbg 1 cycle; ch_sel/btn -> dout 1 cycle; sel_we -> dout 2 cycles.
// No backpressure: every strobe is accepted every cycle on every channel.
module jtpang_dial_ctrl #(
  parameter int CH   = 2,
  parameter int DW   = 8,
  parameter int SENS = 0,
  parameter int MAXD = 31
) (
  input  logic clk,
  input  logic rst,
  jtpang_dial_ctrl_if.slave bus
);
  localparam int AW = DW + SENS;
  localparam logic signed [7:0] PMAX = 8'(MAXD);
  localparam logic signed [7:0] NMAX = 8'(-MAXD);

  logic [AW-1:0]        acc_q  [CH];
  logic [AW-1:0]        acc_d  [CH];
  logic [DW-1:0]        snap_q [CH];
  logic [DW-1:0]        snap_d [CH];
  logic [CH-1:0]        dir_n_q, dir_n_d;
  logic                 dial_mode_q, dial_mode_d;
  logic [7:0]           dout_q, dout_d;

  logic signed [7:0]    dcl    [CH];
  logic [AW-1:0]        dext   [CH];
  logic [DW-1:0]        pos    [CH];

  logic snap_en, clr_en;
  assign snap_en = bus.sel_we & ~bus.sel_din[7];
  assign clr_en  = bus.sel_we &  bus.sel_din[6];

  // Clamp each delta to +/-MAXD, sign-extend to accumulator width, and
  // expose the scaled position (accumulator with SENS fraction bits dropped).
  always_comb begin
    for (int n = 0; n < CH; n++) begin
      dcl[n] = $signed(bus.mouse_dx[8*n +: 8]);
      if (dcl[n] > PMAX)      dcl[n] = PMAX;
      else if (dcl[n] < NMAX) dcl[n] = NMAX;
      dext[n] = AW'(dcl[n]);
      pos[n]  = acc_q[n][AW-1:SENS];
    end
  end

  always_comb begin
    dial_mode_d = dial_mode_q;
    dir_n_d     = dir_n_q;
    for (int n = 0; n < CH; n++) begin
      acc_d[n]  = acc_q[n];
      snap_d[n] = snap_q[n];
      // Snapshot sees the pre-update position of every channel at once.
      if (snap_en) snap_d[n] = pos[n];
      // Clear drops any same-cycle delta.
      if (clr_en)               acc_d[n] = '0;
      else if (bus.mouse_st[n]) acc_d[n] = acc_q[n] + dext[n];
      // Direction follows the sign of the last non-zero delta, even under clear.
      if (bus.mouse_st[n]) begin
        if (dcl[n] > 8'sd0)      dir_n_d[n] = 1'b0;
        else if (dcl[n] < 8'sd0) dir_n_d[n] = 1'b1;
      end
    end
    if (bus.sel_we) dial_mode_d = ~bus.sel_din[7];
  end

  // Read mux works off registered mode/snapshot, so a select write shows on
  // dout two cycles later; unpopulated channels read as all ones.
  always_comb begin
    dout_d = 8'hff;
    if (int'(bus.ch_sel) < CH) begin
      if (dial_mode_q) dout_d = {snap_q[bus.ch_sel][5:0], 2'b11};
      else             dout_d = {bus.btn[bus.ch_sel], 3'b111, ~dir_n_q[bus.ch_sel], 3'b111};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < CH; n++) begin
        acc_q[n]  <= '0;
        snap_q[n] <= '0;
      end
      dir_n_q     <= '1;
      dial_mode_q <= 1'b0;
      dout_q      <= 8'hff;
    end else begin
      for (int n = 0; n < CH; n++) begin
        acc_q[n]  <= acc_d[n];
        snap_q[n] <= snap_d[n];
      end
      dir_n_q     <= dir_n_d;
      dial_mode_q <= dial_mode_d;
      dout_q      <= dout_d;
    end
  end

  always_comb begin
    bus.pos_dbg = '0;
    for (int n = 0; n < CH; n++) bus.pos_dbg[DW*n +: DW] = pos[n];
  end

  assign bus.dial_mode = dial_mode_q;
  assign bus.dout      = dout_q;
endmodule

// File: tb/tb_jtpang_dial_ctrl.sv
module tb_jtpang_dial_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  jtpang_dial_ctrl_if #(.CH(2), .DW(8)) if0 ();
  jtpang_dial_ctrl_if #(.CH(2), .DW(8)) if2 ();
  jtpang_dial_ctrl_if #(.CH(3), .DW(8)) if3 ();

  jtpang_dial_ctrl #(.CH(2), .DW(8), .SENS(0), .MAXD(31)) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
  jtpang_dial_ctrl #(.CH(2), .DW(8), .SENS(2), .MAXD(31)) u2 (.clk(clk), .rst(rst), .bus(if2.slave));
  jtpang_dial_ctrl #(.CH(3), .DW(8), .SENS(0), .MAXD(31)) u3 (.clk(clk), .rst(rst), .bus(if3.slave));

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (if0.dout !== 8'hff) begin errors++; $display("FAIL reset_dout got=%h exp=ff", if0.dout); end
    checks++; if (if0.dial_mode !== 1'b0) begin errors++; $display("FAIL reset_mode got=%b exp=0", if0.dial_mode); end
    checks++; if (if0.pos_dbg !== 16'h0000) begin errors++; $display("FAIL reset_pos got=%h exp=0000", if0.pos_dbg); end
  endtask

  task automatic test_dial_mode;
    if0.sel_din = 8'h00; if0.sel_we = 1'b1; if0.ch_sel = 1'b0;
    tick();
    if0.sel_we = 1'b0;
    checks++; if (if0.dial_mode !== 1'b1) begin errors++; $display("FAIL dial_mode got=%b exp=1", if0.dial_mode); end
    tick();
    checks++; if (if0.dout !== 8'h03) begin errors++; $display("FAIL dial_dout0 got=%h exp=03", if0.dout); end
  endtask

  task automatic test_accumulate;
    if0.mouse_dx = 16'h0005; if0.mouse_st = 2'b01;
    tick(3);
    if0.mouse_st = 2'b00;
    checks++; if (if0.pos_dbg[7:0] !== 8'd15) begin errors++; $display("FAIL accum_pos got=%0d exp=15", if0.pos_dbg[7:0]); end
    if0.sel_din = 8'h00; if0.sel_we = 1'b1;
    tick();
    if0.sel_we = 1'b0;
    tick();
    checks++; if (if0.dout !== 8'h3f) begin errors++; $display("FAIL accum_dout got=%h exp=3f", if0.dout); end
    if0.ch_sel = 1'b1;
    tick();
    checks++; if (if0.dout !== 8'h03) begin errors++; $display("FAIL ch1_dout got=%h exp=03", if0.dout); end
    if0.ch_sel = 1'b0;
  endtask

  task automatic test_clamp;
    if0.sel_din = 8'h40; if0.sel_we = 1'b1;   // clear accumulators
    tick();
    if0.sel_we = 1'b0;
    if0.mouse_dx = 16'h0080; if0.mouse_st = 2'b01;   // -128 clamps to -31
    tick();
    checks++; if (if0.pos_dbg[7:0] !== 8'he1) begin errors++; $display("FAIL clamp_neg got=%h exp=e1", if0.pos_dbg[7:0]); end
    if0.mouse_dx = 16'h007f;                          // +127 clamps to +31
    tick();
    if0.mouse_st = 2'b00;
    checks++; if (if0.pos_dbg !== 16'h0000) begin errors++; $display("FAIL clamp_pos got=%h exp=0000", if0.pos_dbg); end
  endtask

  task automatic test_status;
    if0.mouse_dx = 16'h02ff; if0.mouse_st = 2'b11;    // ch1 +2, ch0 -1
    tick();
    if0.mouse_st = 2'b00;
    // Back-to-back select writes: the last one (status) wins.
    if0.sel_din = 8'h00; if0.sel_we = 1'b1;
    tick();
    if0.sel_din = 8'h80;
    tick();
    if0.sel_we = 1'b0;
    checks++; if (if0.dial_mode !== 1'b0) begin errors++; $display("FAIL status_mode got=%b exp=0", if0.dial_mode); end
    if0.btn = 2'b10; if0.ch_sel = 1'b1;
    tick();
    checks++; if (if0.dout !== 8'hff) begin errors++; $display("FAIL status_ch1 got=%h exp=ff", if0.dout); end
    if0.ch_sel = 1'b0;
    tick();
    checks++; if (if0.dout !== 8'h77) begin errors++; $display("FAIL status_ch0 got=%h exp=77", if0.dout); end
    if0.btn = 2'b11;
    tick();
    checks++; if (if0.dout !== 8'hf7) begin errors++; $display("FAIL status_btn got=%h exp=f7", if0.dout); end
    if0.mouse_dx = 16'h0000; if0.mouse_st = 2'b01;    // zero delta keeps direction
    tick();
    if0.mouse_st = 2'b00;
    tick();
    checks++; if (if0.dout !== 8'hf7) begin errors++; $display("FAIL status_zero got=%h exp=f7", if0.dout); end
  endtask

  task automatic test_snap_collision;
    // ch0 pos is ff; snapshot must take ff while acc moves to 04.
    if0.sel_din = 8'h00; if0.sel_we = 1'b1;
    if0.mouse_dx = 16'h0005; if0.mouse_st = 2'b01;
    tick();
    if0.sel_we = 1'b0; if0.mouse_st = 2'b00;
    checks++; if (if0.pos_dbg[7:0] !== 8'h04) begin errors++; $display("FAIL snapcol_pos got=%h exp=04", if0.pos_dbg[7:0]); end
    tick();
    checks++; if (if0.dout !== 8'hff) begin errors++; $display("FAIL snapcol_dout got=%h exp=ff", if0.dout); end
  endtask

  task automatic test_sens;
    if2.mouse_dx = 16'h0001; if2.mouse_st = 2'b01;
    tick(3);
    checks++; if (if2.pos_dbg[7:0] !== 8'd0) begin errors++; $display("FAIL sens_pos3 got=%0d exp=0", if2.pos_dbg[7:0]); end
    tick();
    checks++; if (if2.pos_dbg[7:0] !== 8'd1) begin errors++; $display("FAIL sens_pos4 got=%0d exp=1", if2.pos_dbg[7:0]); end
    if2.mouse_dx = 16'h0003; if2.sel_din = 8'h40; if2.sel_we = 1'b1; if2.ch_sel = 1'b0;
    tick();
    if2.sel_we = 1'b0; if2.mouse_st = 2'b00;
    checks++; if (if2.pos_dbg !== 16'h0000) begin errors++; $display("FAIL sens_clear got=%h exp=0000", if2.pos_dbg); end
    tick();
    checks++; if (if2.dout !== 8'h07) begin errors++; $display("FAIL sens_snap got=%h exp=07", if2.dout); end
  endtask

  task automatic test_ch_range;
    if3.sel_din = 8'h00; if3.sel_we = 1'b1; if3.ch_sel = 2'd2;
    tick();
    if3.sel_we = 1'b0;
    tick();
    checks++; if (if3.dout !== 8'h03) begin errors++; $display("FAIL ch2_dout got=%h exp=03", if3.dout); end
    if3.ch_sel = 2'd3;
    tick();
    checks++; if (if3.dout !== 8'hff) begin errors++; $display("FAIL ch_oob got=%h exp=ff", if3.dout); end
  endtask

  task automatic test_reset_mid;
    if0.sel_din = 8'h00; if0.sel_we = 1'b1;     // dial mode, then reset hits with strobes
    tick();
    if0.mouse_dx = 16'h0505; if0.mouse_st = 2'b11; rst = 1'b1;
    tick();
    rst = 1'b0; if0.mouse_st = 2'b00; if0.sel_we = 1'b0;
    checks++; if (if0.pos_dbg !== 16'h0000) begin errors++; $display("FAIL rstmid_pos got=%h exp=0000", if0.pos_dbg); end
    checks++; if (if0.dial_mode !== 1'b0) begin errors++; $display("FAIL rstmid_mode got=%b exp=0", if0.dial_mode); end
    checks++; if (if0.dout !== 8'hff) begin errors++; $display("FAIL rstmid_dout got=%h exp=ff", if0.dout); end
    if0.sel_din = 8'h80; if0.sel_we = 1'b0;
    if0.btn = 2'b11; if0.ch_sel = 1'b0;
    tick();
    checks++; if (if0.dout !== 8'hf7) begin errors++; $display("FAIL rstmid_dir got=%h exp=f7", if0.dout); end
  endtask

  initial begin
    rst = 1'b1;
    if0.mouse_dx = '0; if0.mouse_st = '0; if0.btn = '1; if0.sel_we = 1'b0; if0.sel_din = '0; if0.ch_sel = '0;
    if2.mouse_dx = '0; if2.mouse_st = '0; if2.btn = '1; if2.sel_we = 1'b0; if2.sel_din = '0; if2.ch_sel = '0;
    if3.mouse_dx = '0; if3.mouse_st = '0; if3.btn = '1; if3.sel_we = 1'b0; if3.sel_din = '0; if3.ch_sel = '0;
    tick(2);
    test_reset;
    test_dial_mode;
    test_accumulate;
    test_clamp;
    test_status;
    test_snap_collision;
    test_sens;
    test_ch_range;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
